// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV32I issue controller.
// Holds the decoded control-word layout, operand-forwarding select codes,
// the issue FSM state type and small helpers that pull register-use
// information out of a control word.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

  // Decoded control word layout:
  // {Rs1, Rs2, Rd, Rs1_Sel, Rs2_Sel, Rd_Sel, RW, FS, MW, BHW, U, PL, JB, BC}
  localparam int CW_W        = 35;
  localparam int RS1_HI      = 34;
  localparam int RS1_LO      = 30;
  localparam int RS2_HI      = 29;
  localparam int RS2_LO      = 25;
  localparam int RD_HI       = 24;
  localparam int RD_LO       = 20;
  localparam int RS1_SEL_BIT = 19;
  localparam int RS2_SEL_BIT = 18;
  localparam int RD_SEL_HI   = 17;
  localparam int RD_SEL_LO   = 16;
  localparam int RW_BIT      = 15;
  localparam int FS_HI       = 14;
  localparam int FS_LO       = 9;
  localparam int MW_BIT      = 8;
  localparam int BHW_HI      = 7;
  localparam int BHW_LO      = 6;
  localparam int U_BIT       = 5;
  localparam int PL_BIT      = 4;
  localparam int JB_BIT      = 3;
  localparam int BC_HI       = 2;
  localparam int BC_LO       = 0;

  // Rd_Sel value that writes back load data.
  localparam logic [1:0] RD_SEL_LOAD = 2'b00;

  // Operand source select carried with each issued instruction.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } issue_state_e;

  function automatic reg_addr_t cw_rs1(input logic [CW_W-1:0] cw);
    return cw[RS1_HI:RS1_LO];
  endfunction

  function automatic reg_addr_t cw_rs2(input logic [CW_W-1:0] cw);
    return cw[RS2_HI:RS2_LO];
  endfunction

  function automatic reg_addr_t cw_rd(input logic [CW_W-1:0] cw);
    return cw[RD_HI:RD_LO];
  endfunction

  // A register operand is read when its select picks the regfile, or for
  // PC-relative non-jump forms that always consume both sources.
  function automatic logic cw_reads_rs1(input logic [CW_W-1:0] cw);
    return ~cw[RS1_SEL_BIT] | (cw[PL_BIT] & ~cw[JB_BIT]);
  endfunction

  // Stores read Rs2 as data even though the ALU B-input is the immediate.
  function automatic logic cw_reads_rs2(input logic [CW_W-1:0] cw);
    return ~cw[RS2_SEL_BIT] | cw[MW_BIT] | (cw[PL_BIT] & ~cw[JB_BIT]);
  endfunction

  // x0 is hard-wired, so a write to it is never a producer.
  function automatic logic cw_writes(input logic [CW_W-1:0] cw);
    return cw[RW_BIT] & (cw[RD_HI:RD_LO] != '0);
  endfunction

  function automatic logic cw_is_load(input logic [CW_W-1:0] cw);
    return cw[RW_BIT] & (cw[RD_SEL_HI:RD_SEL_LO] == RD_SEL_LOAD)
         & ~cw[MW_BIT] & ~cw[PL_BIT];
  endfunction

  // Youngest producer wins: the instruction leaving EX is newer than the one
  // leaving MEM, so its result is the architecturally correct one.
  function automatic logic [1:0] fwd_sel(input reg_addr_t rs,
                                         input reg_addr_t ex_rd,
                                         input logic      ex_wr,
                                         input reg_addr_t mem_rd,
                                         input logic      mem_wr);
    if (ex_wr && (ex_rd == rs))        return FWD_MEM;
    else if (mem_wr && (mem_rd == rs)) return FWD_WB;
    else                               return FWD_RF;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// issue_ctrl_if
// Bundles the decode-side handshake, the execute-side control and the
// registered ID/EX outputs of the issue controller.
//   id_valid/id_control_word/id_immediate  decode -> issue
//   id_ready                               issue  -> decode
//   ex_ready/ex_redirect                   execute -> issue
//   ex_valid/ex_control_word/ex_immediate  issue  -> execute (ID/EX register)
//   ex_fwd_a/ex_fwd_b                      operand source selects
//   fetch_flush                            issue  -> fetch
//   hazard_count                           saturating load-use bubble count
// master: the surrounding pipeline; slave: issue_ctrl.
// ---------------------------------------------------------------------------
interface issue_ctrl_if #(
  parameter int CNT_W = 16
);
  import riscv_ctrl_pkg::*;

  logic            id_valid;
  logic [CW_W-1:0] id_control_word;
  logic [31:0]     id_immediate;
  logic            id_ready;
  logic            ex_ready;
  logic            ex_redirect;
  logic            ex_valid;
  logic [CW_W-1:0] ex_control_word;
  logic [31:0]     ex_immediate;
  logic [1:0]      ex_fwd_a;
  logic [1:0]      ex_fwd_b;
  logic            fetch_flush;
  logic [CNT_W-1:0] hazard_count;

  modport master (
    output id_valid, id_control_word, id_immediate, ex_ready, ex_redirect,
    input  id_ready, ex_valid, ex_control_word, ex_immediate,
           ex_fwd_a, ex_fwd_b, fetch_flush, hazard_count
  );

  modport slave (
    input  id_valid, id_control_word, id_immediate, ex_ready, ex_redirect,
    output id_ready, ex_valid, ex_control_word, ex_immediate,
           ex_fwd_a, ex_fwd_b, fetch_flush, hazard_count
  );

endinterface

// File: rtl/issue_hazard_detect.sv
// ---------------------------------------------------------------------------
// issue_hazard_detect
// Combinational register-use comparison between the decode instruction and
// the instructions ahead of it.
//   id_valid, id_cw   instruction waiting in decode
//   ex_valid, ex_cw   contents of the ID/EX register (instruction in EX)
//   mem_rd, mem_wr    destination shadow of the instruction in MEM
//   ex_rd, ex_wr      destination shadow of the instruction in EX
//   hazard            load in EX feeds a source of the decode instruction
//   fwd_a, fwd_b      operand source selects for the decode instruction
// ---------------------------------------------------------------------------
module issue_hazard_detect
  import riscv_ctrl_pkg::*;
(
  input  logic            id_valid,
  input  logic [CW_W-1:0] id_cw,
  input  logic            ex_valid,
  input  logic [CW_W-1:0] ex_cw,
  input  reg_addr_t       mem_rd,
  input  logic            mem_wr,
  output reg_addr_t       ex_rd,
  output logic            ex_wr,
  output logic            hazard,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      ex_ld;
  logic      rs1_hit;
  logic      rs2_hit;

  assign id_rs1 = cw_rs1(id_cw);
  assign id_rs2 = cw_rs2(id_cw);
  assign ex_rd  = cw_rd(ex_cw);
  assign ex_wr  = ex_valid & cw_writes(ex_cw);

  // A load into x0 produces nothing, so it can never stall a consumer.
  assign ex_ld   = ex_valid & cw_is_load(ex_cw) & (ex_rd != '0);
  assign rs1_hit = cw_reads_rs1(id_cw) & (id_rs1 == ex_rd);
  assign rs2_hit = cw_reads_rs2(id_cw) & (id_rs2 == ex_rd);
  assign hazard  = id_valid & ex_ld & (rs1_hit | rs2_hit);

  // A load still in EX could select FWD_MEM here, but the hazard stall
  // always separates it from its consumer first, so that value never issues.
  assign fwd_a = fwd_sel(id_rs1, ex_rd, ex_wr, mem_rd, mem_wr);
  assign fwd_b = fwd_sel(id_rs2, ex_rd, ex_wr, mem_rd, mem_wr);

endmodule

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
// Issue stage between decode and execute. Owns the ID/EX register, stalls
// one cycle on a load-use dependency, squashes wrong-path decode output for
// FLUSH_CYCLES cycles after a taken branch/jump, and attaches forwarding
// selects to each issued instruction.
//   clk, rst_n  pipeline clock, asynchronous active-low reset
//   bus         issue_ctrl_if.slave (decode handshake, EX control, ID/EX
//               outputs, fetch_flush, hazard_count)
// Parameters:
//   FLUSH_CYCLES  post-redirect cycles of discarded decode output (1..7)
//   CNT_W         width of the saturating load-use bubble counter
// ex_ready=0 freezes every register, the FSM and the counters.
// ---------------------------------------------------------------------------
module issue_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  issue_ctrl_if.slave bus
);

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  issue_state_e     state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;

  logic             ex_valid_q;
  logic [CW_W-1:0]  ex_cw_q;
  logic [31:0]      ex_imm_q;
  logic [1:0]       fwd_a_q, fwd_b_q;
  reg_addr_t        mem_rd_q;
  logic             mem_wr_q;
  logic [CNT_W-1:0] hz_cnt_q;

  reg_addr_t        ex_rd;
  logic             ex_wr;
  logic             hazard;
  logic [1:0]       fwd_a, fwd_b;

  logic             id_ready;
  logic             fetch_flush;
  logic             issue_id;
  logic             count_hz;

  issue_hazard_detect u_hazard (
    .id_valid (bus.id_valid),
    .id_cw    (bus.id_control_word),
    .ex_valid (ex_valid_q),
    .ex_cw    (ex_cw_q),
    .mem_rd   (mem_rd_q),
    .mem_wr   (mem_wr_q),
    .ex_rd    (ex_rd),
    .ex_wr    (ex_wr),
    .hazard   (hazard),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  // Next-state and handshake decode. Anything not issuing the decode
  // instruction loads a bubble into ID/EX.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_ready    = bus.ex_ready;
    issue_id    = 1'b0;
    count_hz    = 1'b0;
    fetch_flush = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_redirect && bus.ex_ready) begin
          // Wrong-path decode slot is consumed and dropped; the redirect
          // also masks any hazard seen in the same cycle.
          id_ready    = 1'b1;
          fetch_flush = 1'b1;
          state_d     = FLUSH;
          cnt_d       = FLUSH_LOAD;
        end else if (hazard) begin
          id_ready = 1'b0;
          count_hz = bus.ex_ready;
        end else begin
          issue_id = bus.id_valid;
        end
      end

      FLUSH: begin
        // Only bubbles sit in EX here, so ex_redirect cannot be genuine.
        fetch_flush = 1'b1;
        if (bus.ex_ready) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 3'd1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath half of ID/EX is reset as well, because a bubble
      // must read as an all-zero word from the first cycle.
      state_q    <= RUN;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_cw_q    <= '0;
      ex_imm_q   <= '0;
      fwd_a_q    <= FWD_RF;
      fwd_b_q    <= FWD_RF;
      mem_rd_q   <= '0;
      mem_wr_q   <= 1'b0;
      hz_cnt_q   <= '0;
    end else if (bus.ex_ready) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= issue_id;
      ex_cw_q    <= issue_id ? bus.id_control_word : '0;
      ex_imm_q   <= issue_id ? bus.id_immediate    : '0;
      fwd_a_q    <= issue_id ? fwd_a : FWD_RF;
      fwd_b_q    <= issue_id ? fwd_b : FWD_RF;
      // The instruction leaving EX becomes the MEM-stage producer.
      mem_rd_q   <= ex_rd;
      mem_wr_q   <= ex_wr;
      if (count_hz && (hz_cnt_q != CNT_MAX)) begin
        hz_cnt_q <= hz_cnt_q + 1'b1;
      end
    end
  end

  assign bus.id_ready        = id_ready;
  assign bus.fetch_flush     = fetch_flush;
  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_control_word = ex_cw_q;
  assign bus.ex_immediate    = ex_imm_q;
  assign bus.ex_fwd_a        = fwd_a_q;
  assign bus.ex_fwd_b        = fwd_b_q;
  assign bus.hazard_count    = hz_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_ctrl
// Directed scenarios followed by randomized traffic for issue_ctrl. A second
// instance with a 4-bit counter sees the same stimulus so counter saturation
// is reachable quickly. Expected values come from a slot-level pipeline model:
// what sits in EX and MEM, how many decode slots are still to be discarded,
// and how many load-use bubbles have been charged.
// ---------------------------------------------------------------------------
module tb_issue_ctrl;
  import riscv_ctrl_pkg::*;

  localparam int FC      = 2;
  localparam int SAT_MAX = 15;
  localparam int HZ_MAX  = 65535;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  issue_ctrl_if #(.CNT_W(16)) bus ();
  issue_ctrl_if #(.CNT_W(4))  sbus ();

  assign sbus.id_valid        = bus.id_valid;
  assign sbus.id_control_word = bus.id_control_word;
  assign sbus.id_immediate    = bus.id_immediate;
  assign sbus.ex_ready        = bus.ex_ready;
  assign sbus.ex_redirect     = bus.ex_redirect;

  issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  issue_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---- reference model state ----
  logic        m_valid;
  logic [34:0] m_cw;
  logic [31:0] m_imm;
  logic [1:0]  m_fa, m_fb;
  logic [4:0]  m_mem_rd;
  logic        m_mem_wr;
  int          m_flush_left;
  int          m_hz, m_hz_s;
  logic        e_redir, e_ld, e_rdy, e_ff;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] mk(input int rs1, input int rs2, input int rd,
                                     input bit s1, input bit s2, input logic [1:0] rdsel,
                                     input bit rw, input bit mw, input bit pl, input bit jb);
    return {5'(rs1), 5'(rs2), 5'(rd), s1, s2, rdsel, rw, 6'h00, mw, 2'b10, 1'b0, pl, jb, 3'b000};
  endfunction

  function automatic bit t_reads1(input logic [34:0] cw);
    return !cw[19] || (cw[4] && !cw[3]);
  endfunction
  function automatic bit t_reads2(input logic [34:0] cw);
    return !cw[18] || cw[8] || (cw[4] && !cw[3]);
  endfunction
  function automatic bit t_writes(input logic [34:0] cw);
    return cw[15] && (cw[24:20] != 5'd0);
  endfunction
  function automatic bit t_load(input logic [34:0] cw);
    return cw[15] && (cw[17:16] == 2'b00) && !cw[8] && !cw[4];
  endfunction

  // Source is found in the newest producer first (the one now in EX).
  function automatic logic [1:0] t_src(input logic [4:0] r);
    if (r != 5'd0 && m_valid && t_writes(m_cw) && m_cw[24:20] == r) return 2'b01;
    if (r != 5'd0 && m_mem_wr && m_mem_rd == r)                    return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cw = '0; m_imm = '0; m_fa = 0; m_fb = 0;
    m_mem_rd = 0; m_mem_wr = 0; m_flush_left = 0; m_hz = 0; m_hz_s = 0;
  endtask

  task automatic model_comb();
    logic [34:0] c;
    logic [4:0]  d;
    c = bus.id_control_word;
    d = m_cw[24:20];
    e_redir = (m_flush_left == 0) && bus.ex_redirect && bus.ex_ready;
    e_ld    = (m_flush_left == 0) && m_valid && t_load(m_cw) && d != 5'd0 && bus.id_valid &&
              ((t_reads1(c) && c[34:30] == d) || (t_reads2(c) && c[29:25] == d));
    e_ff    = e_redir || (m_flush_left > 0);
    e_rdy   = e_redir ? 1'b1 : (e_ld ? 1'b0 : bus.ex_ready);
  endtask

  task automatic model_step();
    logic [4:0] n_rd;
    logic       n_wr, take;
    logic [1:0] fa, fb;
    if (!rst_n || !bus.ex_ready) return;
    n_rd = m_cw[24:20];
    n_wr = m_valid && t_writes(m_cw);
    fa   = t_src(bus.id_control_word[34:30]);
    fb   = t_src(bus.id_control_word[29:25]);
    take = 0;
    if (e_redir)               m_flush_left = FC;
    else if (m_flush_left > 0) m_flush_left--;
    else if (e_ld) begin
      m_hz   = (m_hz   < HZ_MAX)  ? m_hz + 1   : m_hz;
      m_hz_s = (m_hz_s < SAT_MAX) ? m_hz_s + 1 : m_hz_s;
    end else take = bus.id_valid;
    m_valid  = take;
    m_cw     = take ? bus.id_control_word : '0;
    m_imm    = take ? bus.id_immediate : '0;
    m_fa     = take ? fa : 2'b00;
    m_fb     = take ? fb : 2'b00;
    m_mem_rd = n_rd;
    m_mem_wr = n_wr;
  endtask

  // One clock: compare at the falling edge, advance the model, step past
  // the rising edge.
  task automatic tick();
    @(negedge clk);
    model_comb();
    check("id_ready",    bus.id_ready,        e_rdy);
    check("fetch_flush", bus.fetch_flush,     e_ff);
    check("ex_valid",    bus.ex_valid,        m_valid);
    check("ex_cw",       bus.ex_control_word, m_cw);
    check("ex_imm",      bus.ex_immediate,    m_imm);
    check("ex_fwd_a",    bus.ex_fwd_a,        m_fa);
    check("ex_fwd_b",    bus.ex_fwd_b,        m_fb);
    check("hz_count",    bus.hazard_count,    m_hz);
    check("hz_count_sat", sbus.hazard_count,  m_hz_s);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [34:0] cw, input logic [31:0] imm,
                       input bit rdy, input bit redir);
    bus.id_valid        = v;
    bus.id_control_word = cw;
    bus.id_immediate    = imm;
    bus.ex_ready        = rdy;
    bus.ex_redirect     = redir;
  endtask

  function automatic logic [34:0] rand_cw();
    logic [63:0] r;
    logic [34:0] cw;
    r  = {$urandom, $urandom};
    cw = r[34:0];
    cw[34:30] = 5'($urandom_range(0, 3));
    cw[29:25] = 5'($urandom_range(0, 3));
    cw[24:20] = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 3) begin
      cw[15] = 1'b1; cw[17:16] = 2'b00; cw[8] = 1'b0; cw[4] = 1'b0;
    end
    return cw;
  endfunction

  logic [34:0] LW5, ADD6, ADDI3, SUB4, LW0, ADD7, I_A, I_B, LWS;

  initial begin
    LW5   = mk(6, 0, 5, 0, 1, 2'b00, 1, 0, 0, 0);  // lw   x5, 0(x6)
    ADD6  = mk(5, 7, 6, 0, 0, 2'b01, 1, 0, 0, 0);  // add  x6, x5, x7
    ADDI3 = mk(0, 0, 3, 0, 1, 2'b01, 1, 0, 0, 0);  // addi x3, x0, imm
    SUB4  = mk(3, 3, 4, 0, 0, 2'b01, 1, 0, 0, 0);  // sub  x4, x3, x3
    LW0   = mk(6, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0);  // lw   x0, 0(x6)
    ADD7  = mk(0, 0, 7, 0, 0, 2'b01, 1, 0, 0, 0);  // add  x7, x0, x0
    I_A   = mk(2, 0, 1, 0, 1, 2'b01, 1, 0, 0, 0);  // addi x1, x2, imm
    I_B   = mk(1, 1, 2, 0, 0, 2'b01, 1, 0, 0, 0);  // add  x2, x1, x1
    LWS   = mk(5, 0, 5, 0, 1, 2'b00, 1, 0, 0, 0);  // lw   x5, 0(x5)

    // Reset state
    rst_n = 1'b0;
    model_reset();
    drive(0, '0, '0, 1, 0);
    #1;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_id_ready", bus.id_ready, 1'b1);
    check("rst_flush",    bus.fetch_flush, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load-use: one bubble, then forward from WB
    drive(1, LW5, 32'h10, 1, 0); tick();
    drive(1, ADD6, 32'h20, 1, 0); #1;
    check("lu_stall", bus.id_ready, 1'b0);
    tick();
    check("lu_bubble", bus.ex_valid, 1'b0);
    check("lu_resume", bus.id_ready, 1'b1);
    tick();
    check("lu_cw",    bus.ex_control_word, ADD6);
    check("lu_fwd_a", bus.ex_fwd_a, 2'b10);
    check("lu_hz",    bus.hazard_count, 16'd1);

    // ALU producer directly ahead: no stall, forward from MEM on both sides
    drive(1, ADDI3, 32'h1, 1, 0); tick();
    drive(1, SUB4, 32'h0, 1, 0); #1;
    check("alu_ready", bus.id_ready, 1'b1);
    tick();
    check("alu_fwd_a", bus.ex_fwd_a, 2'b01);
    check("alu_fwd_b", bus.ex_fwd_b, 2'b01);

    // Load to x0 never creates a dependency
    drive(1, LW0, 32'h4, 1, 0); tick();
    drive(1, ADD7, 32'h0, 1, 0); #1;
    check("x0_ready", bus.id_ready, 1'b1);
    tick();
    check("x0_fwd_a", bus.ex_fwd_a, 2'b00);
    check("x0_fwd_b", bus.ex_fwd_b, 2'b00);
    check("x0_hz",    bus.hazard_count, 16'd1);

    // Redirect: 1+FC bubbles; redirect raised during FLUSH is ignored
    drive(1, I_A, 32'h8, 1, 1); #1;
    check("rd_flush0", bus.fetch_flush, 1'b1);
    check("rd_ready0", bus.id_ready, 1'b1);
    tick();
    check("rd_bubble0", bus.ex_valid, 1'b0);
    drive(1, I_B, 32'h9, 1, 1);
    for (int i = 0; i < FC; i++) begin
      #1;
      check("rd_flush", bus.fetch_flush, 1'b1);
      tick();
      check("rd_bubble", bus.ex_valid, 1'b0);
    end
    drive(1, I_B, 32'h9, 1, 0); #1;
    check("rd_run_flush", bus.fetch_flush, 1'b0);
    tick();
    check("rd_issue_v",  bus.ex_valid, 1'b1);
    check("rd_issue_cw", bus.ex_control_word, I_B);

    // Redirect coinciding with a load-use hazard charges no bubble
    drive(1, LW5, 32'h10, 1, 0); tick();
    drive(1, ADD6, 32'h20, 1, 1); #1;
    check("rh_ready", bus.id_ready, 1'b1);
    tick();
    check("rh_hz",    bus.hazard_count, 16'd1);
    check("rh_bub",   bus.ex_valid, 1'b0);
    drive(0, '0, '0, 1, 0);
    tick(); tick(); #1;
    check("rh_run", bus.fetch_flush, 1'b0);

    // ex_ready low during a stall freezes everything
    drive(1, LW5, 32'h30, 1, 0); tick();
    drive(1, ADD6, 32'h40, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fz_ready", bus.id_ready, 1'b0);
      check("fz_cw",    bus.ex_control_word, LW5);
      check("fz_hz",    bus.hazard_count, 16'd1);
      tick();
    end
    drive(1, ADD6, 32'h40, 1, 0); #1;
    check("fz_stall", bus.id_ready, 1'b0);
    tick();
    check("fz_bubble", bus.ex_valid, 1'b0);
    check("fz_hz2",    bus.hazard_count, 16'd2);
    tick();
    check("fz_cw2",  bus.ex_control_word, ADD6);
    check("fz_fwd",  bus.ex_fwd_a, 2'b10);

    // Reset in the middle of FLUSH
    drive(1, I_A, 32'h5, 1, 1); tick();
    drive(0, '0, '0, 1, 0); #1;
    check("rf_in_flush", bus.fetch_flush, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rf_valid", bus.ex_valid, 1'b0);
    check("rf_flush", bus.fetch_flush, 1'b0);
    check("rf_ready", bus.id_ready, 1'b1);
    check("rf_hz",    bus.hazard_count, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back self-dependent loads drive the narrow counter to saturation
    drive(1, LWS, 32'h0, 1, 0);
    for (int i = 0; i < 40; i++) tick();
    check("sat_main", bus.hazard_count, 16'd20);
    check("sat_narrow", sbus.hazard_count, 4'hF);
    drive(0, '0, '0, 1, 0); tick();

    // Randomized traffic with one reset pulse midway
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        drive(0, '0, '0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      drive($urandom_range(0, 9) < 7, rand_cw(), $urandom,
            $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the instruction decoder and the execute stage of the RV32I pipeline. It owns the ID/EX pipeline register and accepts the 35-bit control word and immediate from decode. It detects load-use hazards against the instructions in EX and MEM, inserts bubbles, and flushes wrong-path instructions after a taken branch or jump. It computes the operand-forwarding selects that travel with each issued instruction.

## Interface
Parameters:
- FLUSH_CYCLES, 2: number of post-redirect cycles during which decode output is discarded (legal range 1–7).
- CNT_W, 16: width of the saturating hazard counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_control_word  in  35  decoded word, {Rs1[34:30], Rs2[29:25], Rd[24:20], Rs1_Sel[19], Rs2_Sel[18], Rd_Sel[17:16], RW[15], FS[14:9], MW[8], BHW[7:6], U[5], PL[4], JB[3], BC[2:0]}.
- id_immediate  in  32  decoded immediate.
- id_ready  out  1  controller consumes the decode instruction this cycle.
- ex_ready  in  1  EX/MEM advance enable; 0 freezes every register in this block.
- ex_redirect  in  1  instruction in EX is a taken branch or jump; qualified by ex_ready.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_control_word  out  35  registered control word (all-zero when bubble).
- ex_immediate  out  32  registered immediate (zero when bubble).
- ex_fwd_a, ex_fwd_b  out  2  operand source: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
- fetch_flush  out  1  fetch must discard its in-flight instruction(s).
- hazard_count  out  CNT_W  saturating count of load-use bubbles.

## Operation
- Register-use decode:
  - reads_rs1 = (Rs1_Sel==0) | (PL & ~JB).
  - reads_rs2 = (Rs2_Sel==0) | MW | (PL & ~JB).
  - writes = RW & (Rd != 0).
  - is_load = RW & (Rd_Sel==00) & ~MW & ~PL.
  - Address 0 never matches.
- Shadow state:
  - {ex_rd, ex_wr, ex_ld} is taken from the ID/EX register.
  - {mem_rd, mem_wr} is loaded from the EX shadow whenever ex_ready=1.
- FSM states RUN, FLUSH; reset state RUN.
- RUN:
  - Load-use hazard: ex_valid & ex_ld & id_valid, with a match on (reads_rs1 & Rs1==ex_rd) | (reads_rs2 & Rs2==ex_rd).
  - On a hazard: id_ready=0, a bubble loads into ID/EX, and hazard_count increments (saturates at all-ones).
  - Otherwise id_ready=ex_ready, and the ID instruction issues when id_valid, or a bubble issues when id_valid=0.
- Forward select per operand, computed at issue:
  - 01 if the EX-shadow writes that register.
  - Else 10 if the MEM-shadow writes it.
  - Else 00.
  - 01 has priority over 10.
  - Loads never produce 01, because a hazard stall precedes any such issue.
- Redirect (ex_redirect & ex_ready):
  - Has priority over hazard and issue.
  - Any ID instruction is consumed (id_ready=1) but discarded, and ID/EX loads a bubble.
  - State goes to FLUSH with cnt=FLUSH_CYCLES-1.
- FLUSH:
  - id_ready=ex_ready, decode output is discarded, and bubbles issue.
  - cnt decrements on each ex_ready cycle; when cnt==0 and ex_ready, go to RUN.
  - ex_redirect is ignored in FLUSH, because only bubbles occupy EX.
- fetch_flush = (ex_redirect & ex_ready & state==RUN) | (state==FLUSH); combinational.

## Timing
- Reset values:
  - ex_valid=0, ex_control_word=0, ex_immediate=0, ex_fwd_a/b=00, hazard_count=0.
  - All shadows cleared, state RUN, cnt=0.
  - Consequently id_ready=ex_ready and fetch_flush=0 while in reset.
- Issue latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Load-use costs exactly 1 bubble; the dependent instruction then issues with fwd=10.
- Redirect costs 1+FLUSH_CYCLES discarded decode slots.
- ex_ready=0: all registers, FSM and counters hold; id_ready=0.
- A hazard condition that coincides with a redirect counts no bubble.
- Reset asserted mid-FLUSH or mid-stall returns to the reset state immediately; no partial instruction survives.

## Structure
- Package riscv_ctrl_pkg holds:
  - CW_W=35 and the field bit positions (RS1_HI/LO … BC_HI/LO).
  - The FWD_RF/FWD_MEM/FWD_WB constants.
  - The state enum {RUN, FLUSH}.
- One sub-module, issue_hazard_detect: a combinational register-use decode plus hazard and forward comparison. The FSM, ID/EX register, shadows and counters stay in issue_ctrl.

## Test plan
- LW x5 then ADD x6,x5,x7 back-to-back → one cycle with id_ready=0 and ex_valid=0, then ADD issues with ex_fwd_a=10; hazard_count=1.
- ADDI x3 then SUB x4,x3,x3 → no stall; SUB issues with ex_fwd_a=ex_fwd_b=01.
- LW x0 followed by a use of x0 → no stall, fwd=00.
- BEQ taken (ex_redirect=1) with the next instruction valid in ID, FLUSH_CYCLES=2 → fetch_flush high for 3 cycles, 3 bubbles issued, RUN resumes, next valid instruction issues.
- ex_ready=0 held for 4 cycles during a load-use stall → all outputs frozen; on release the bubble and then the dependent instruction proceed; hazard_count=1.
- rst_n asserted during FLUSH → ex_valid=0, fetch_flush=0, state RUN immediately; 2^CNT_W+3 hazards → hazard_count stays all-ones.
